// File: rtl/concat_repl_stream.sv
// Flow-controlled concat/replicate packer: each accepted {a,b} word is packed
// into {cat, rep_a, rep_b} and buffered in a DEPTH-entry FIFO toward the sink.
module concat_repl_stream #(
    parameter int unsigned A_W     = 4,
    parameter int unsigned B_W     = 2,
    parameter int unsigned CAT_PAD = 2,
    parameter int unsigned REP_A   = 1,
    parameter int unsigned REP_B   = 3,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned IN_W    = A_W + B_W,
    parameter int unsigned CAT_W   = A_W + B_W + CAT_PAD,
    parameter int unsigned OUT_W   = CAT_W + REP_A * A_W + REP_B * B_W,
    parameter int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_flat,
    input  logic             in_swap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_flat,
    output logic [LVL_W-1:0] level,
    output logic [15:0]      xfer_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [CAT_W-1:0] cat;
    logic [OUT_W-1:0] packed_word;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic [LVL_W-1:0] level_next;
    logic [OUT_W-1:0] head_next;
    logic             alive;
    logic             push, pop;

    always_comb begin
        a           = in_flat[IN_W-1:B_W];
        b           = in_flat[B_W-1:0];
        cat         = in_swap ? CAT_W'({b, a}) : CAT_W'({a, b});
        packed_word = {cat, {REP_A{a}}, {REP_B{b}}};
    end

    assign in_ready = alive && (level < LVL_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // The head register is loaded with next cycle's head so out_flat stays a
    // flop; a push lands directly at the head when it writes the slot rd_ptr moves to.
    always_comb begin
        rd_ptr_next = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_ptr_next = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        level_next  = level;
        if (push && !pop)
            level_next = level + LVL_W'(1);
        else if (pop && !push)
            level_next = level - LVL_W'(1);
        head_next = '0;
        if (level_next != '0) begin
            if (push && (wr_ptr == rd_ptr_next))
                head_next = packed_word;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= packed_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive     <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_flat  <= '0;
            xfer_cnt  <= '0;
        end else begin
            alive     <= 1'b1;
            rd_ptr    <= rd_ptr_next;
            wr_ptr    <= wr_ptr_next;
            level     <= level_next;
            out_valid <= (level_next != '0);
            out_flat  <= head_next;
            if (pop)
                xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule
